// File: rtl/inst_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue_pkg
// Purpose  : Opcodes, fetch FSM state encoding and B/J immediate helpers
//            shared by the prefetch queue and decode.
// Revision : 1.0 - initial release
// ============================================================================
package inst_prefetch_queue_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } pfq_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_fifo
// Purpose  : DEPTH-entry FIFO with flush; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d                = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Purpose  : Instruction fetch front end: one request in flight, prefetch
//            FIFO, redirect/flush; static prediction when
//            INST_PREFETCH_STATIC_PRED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] BOOT_ADDR = {XLEN{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_en,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   mem_req_en,
  output logic [XLEN-1:0]        mem_req_addr,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_pred_taken,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import inst_prefetch_queue_pkg::*;

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            FW      = 2 * XLEN + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  pfq_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_en_q, req_en_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;

  logic            push;
  logic            pop;
  logic            pred_taken;
  logic            is_jalr;
  logic [XLEN-1:0] next_pc;
  logic [CW-1:0]   count_after_pop;
  logic [FW-1:0]   head;

  // Responses during a redirect or while draining are stale and never pushed.
  assign push            = req_en_q & mem_ready & ~redirect_en & (state_q != ST_DRAIN);
  assign pop             = out_valid & out_ready;
  assign out_valid       = (fifo_count != '0);
  assign count_after_pop = fifo_count - CW'(pop);

`ifdef INST_PREFETCH_STATIC_PRED_EN
  always_comb begin
    pred_taken = 1'b0;
    is_jalr    = 1'b0;
    next_pc    = req_addr_q + XLEN'(4);
    case (mem_rdata[6:0])
      OPC_BRANCH: begin
        if (mem_rdata[31]) begin
          pred_taken = 1'b1;
          next_pc    = req_addr_q + XLEN'($signed(imm_b(mem_rdata[31:0])));
        end
      end
      OPC_JAL: begin
        pred_taken = 1'b1;
        next_pc    = req_addr_q + XLEN'($signed(imm_j(mem_rdata[31:0])));
      end
      OPC_JALR: is_jalr = 1'b1;
      default:  ;
    endcase
  end
`else
  assign pred_taken = 1'b0;
  assign is_jalr    = 1'b0;
  assign next_pc    = req_addr_q + XLEN'(4);
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_en_d   = req_en_q;
    req_addr_d = req_addr_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      if (req_en_q && !mem_ready) begin
        state_d = ST_DRAIN;
      end else begin
        state_d    = ST_FETCH;
        req_en_d   = 1'b1;
        req_addr_d = redirect_pc;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (req_en_q) begin
            if (mem_ready) begin
              req_en_d   = 1'b0;
              fetch_pc_d = next_pc;
              if (is_jalr) state_d = ST_HOLD;
            end
          end else if (count_after_pop < DEPTH_C) begin
            req_en_d   = 1'b1;
            req_addr_d = fetch_pc_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (count_after_pop < DEPTH_C) begin
            state_d    = ST_FETCH;
            req_en_d   = 1'b1;
            req_addr_d = fetch_pc_q;
          end
        end
        ST_DRAIN: begin
          // Old address stays on the bus until its response is swallowed.
          if (mem_ready) begin
            state_d    = ST_FETCH;
            req_en_d   = 1'b1;
            req_addr_d = fetch_pc_q;
          end
        end
        ST_HOLD: ;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= BOOT_ADDR;
      req_en_q   <= 1'b0;
      req_addr_q <= BOOT_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_en_q   <= req_en_d;
      req_addr_q <= req_addr_d;
    end
  end

  inst_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_en),
    .push  (push),
    .wdata ({pred_taken, req_addr_q, mem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign mem_req_en     = req_en_q;
  assign mem_req_addr   = req_addr_q;
  assign out_pred_taken = head[FW-1];
  assign out_pc         = head[FW-2:XLEN];
  assign out_inst       = head[XLEN-1:0];

endmodule
`default_nettype wire
